// File: rtl/spu_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spu_branch_pkg
// Purpose  : Shared opcodes, format codes and pipeline types for the SPU
//            branch pipe.
// Revision : 1.0 - initial release
// ============================================================================
package spu_branch_pkg;

   // RR-format branch opcodes, op[0:10]
   localparam logic [10:0] OP_BI    = 11'b00110101000;
   localparam logic [10:0] OP_BISL  = 11'b00110101001;
   localparam logic [10:0] OP_BIZ   = 11'b00100101000;
   localparam logic [10:0] OP_BINZ  = 11'b00100101001;

   // RI16-format branch opcodes, op[2:10]
   localparam logic [8:0]  OP_BR    = 9'b001100100;
   localparam logic [8:0]  OP_BRSL  = 9'b001100110;
   localparam logic [8:0]  OP_BRA   = 9'b001100000;
   localparam logic [8:0]  OP_BRZ   = 9'b001000000;
   localparam logic [8:0]  OP_BRNZ  = 9'b001000010;
   localparam logic [8:0]  OP_BRHZ  = 9'b001000100;
   localparam logic [8:0]  OP_BRHNZ = 9'b001000110;

   localparam logic [2:0]  FMT_RR   = 3'd0;
   localparam logic [2:0]  FMT_RI16 = 3'd5;

   // rt holds only the preferred-slot link word; pc is sized for the widest PC.
   typedef struct packed {
      logic [31:0] rt;
      logic [6:0]  rt_addr;
      logic        reg_write;
      logic [31:0] pc;
      logic        taken;
   } br_stage_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SHADOW = 1'b1
   } shadow_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_decode.sv
`default_nettype none
// ============================================================================
// Module   : branch_decode
// Purpose  : Combinational decode of one branch instruction into a stage entry.
// Revision : 1.0 - initial release
// ============================================================================
module branch_decode
   import spu_branch_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int REG_W = 128
) (
   input  logic [0:10]      op,
   input  logic [2:0]       format,
   input  logic [6:0]       rt_addr,
   input  logic [0:REG_W-1] ra,
   input  logic [0:REG_W-1] rt_st,
   input  logic [0:17]      imm,
   input  logic             reg_write,
   input  logic [PC_W-1:0]  pc_in,
   output br_stage_t        dec
);

   logic [PC_W-1:0] w_rel_tgt;
   logic [PC_W-1:0] w_abs_tgt;
   logic [PC_W-1:0] w_ind_tgt;
   logic [PC_W-1:0] w_link;
   logic [PC_W-1:0] w_tgt;
   logic            w_word_zero;
   logic            w_half_zero;
   logic            w_taken;
   logic            w_link_op;
   logic            w_unused_bits;

   // All target arithmetic wraps at PC_W bits.
   assign w_rel_tgt   = pc_in + PC_W'(imm[2:17]);
   assign w_abs_tgt   = PC_W'(imm[2:17]);
   assign w_ind_tgt   = ra[32-PC_W:31];
   assign w_link      = pc_in + PC_W'(1);
   assign w_word_zero = (rt_st[0:31] == 32'd0);
   assign w_half_zero = (rt_st[16:31] == 16'd0);

   assign w_unused_bits = ^{ra, rt_st, imm[0:1]};

   always_comb begin
      w_taken   = 1'b0;
      w_link_op = 1'b0;
      w_tgt     = w_rel_tgt;
      case (format)
         FMT_RR: begin
            w_tgt = w_ind_tgt;
            case (op)
               OP_BI:   w_taken = 1'b1;
               OP_BISL: begin
                  w_taken   = 1'b1;
                  w_link_op = 1'b1;
               end
               OP_BIZ:  w_taken = w_word_zero;
               OP_BINZ: w_taken = !w_word_zero;
               default: w_taken = 1'b0;
            endcase
         end
         FMT_RI16: begin
            case (op[2:10])
               OP_BR:    w_taken = 1'b1;
               OP_BRSL:  begin
                  w_taken   = 1'b1;
                  w_link_op = 1'b1;
               end
               OP_BRA:   begin
                  w_taken = 1'b1;
                  w_tgt   = w_abs_tgt;
               end
               OP_BRZ:   w_taken = w_word_zero;
               OP_BRNZ:  w_taken = !w_word_zero;
               OP_BRHZ:  w_taken = w_half_zero;
               OP_BRHNZ: w_taken = !w_half_zero;
               default:  w_taken = 1'b0;
            endcase
         end
         default: w_taken = 1'b0;
      endcase

      // Unknown encodings and not-taken plain branches collapse to an all-zero entry.
      dec       = '0;
      dec.taken = w_taken;
      dec.pc    = w_taken ? 32'(w_tgt) : 32'd0;
      if (w_link_op) begin
         dec.rt        = 32'(w_link);
         dec.rt_addr   = rt_addr;
         dec.reg_write = reg_write;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_unit_p.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit_p
// Purpose  : SPU odd-pipe branch unit: fixed-latency result pipe plus a
//            shadow FSM that squashes wrong-path issue after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit_p
   import spu_branch_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int REG_W   = 128,
   parameter int LATENCY = 2,
   parameter int SHADOW  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:10]      op,
   input  logic [2:0]       format,
   input  logic [6:0]       rt_addr,
   input  logic [0:REG_W-1] ra,
   input  logic [0:REG_W-1] rt_st,
   input  logic [0:17]      imm,
   input  logic             reg_write,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             first,
   output logic [0:REG_W-1] rt_wb,
   output logic [6:0]       rt_addr_wb,
   output logic             reg_write_wb,
   output logic [PC_W-1:0]  pc_wb,
   output logic             branch_taken,
   output logic             branch_kill,
   output logic             shadow_active
);

   localparam logic [2:0] c_shadow_load = 3'((SHADOW > 0) ? SHADOW - 1 : 0);

   br_stage_t     w_dec;
   br_stage_t     w_wb;
   br_stage_t     stg_q [1:LATENCY];
   br_stage_t     stg_d [1:LATENCY];
   shadow_state_t state_q;
   shadow_state_t state_d;
   logic [2:0]    cnt_q;
   logic [2:0]    cnt_d;
   logic          w_in_flight;
   logic          w_suppress;
   logic          w_unused_pc;

   branch_decode #(
      .PC_W  (PC_W),
      .REG_W (REG_W)
   ) u_decode (
      .op        (op),
      .format    (format),
      .rt_addr   (rt_addr),
      .ra        (ra),
      .rt_st     (rt_st),
      .imm       (imm),
      .reg_write (reg_write),
      .pc_in     (pc_in),
      .dec       (w_dec)
   );

   always_comb begin
      w_in_flight = 1'b0;
      for (int i = 1; i <= LATENCY; i++) begin
         w_in_flight = w_in_flight | stg_q[i].taken;
      end
   end

   // Anything issued behind an unresolved or just-resolved redirect is wrong-path.
   assign w_suppress  = (state_q == spu_branch_pkg::SHADOW) || w_in_flight;
   assign branch_kill = w_dec.taken && first && !w_suppress;

   always_comb begin
      stg_d[1] = w_suppress ? '0 : w_dec;
      for (int i = 2; i <= LATENCY; i++) begin
         stg_d[i] = stg_q[i-1];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         spu_branch_pkg::IDLE: begin
            if (w_wb.taken && (SHADOW > 0)) begin
               state_d = spu_branch_pkg::SHADOW;
               cnt_d   = c_shadow_load;
            end
         end
         spu_branch_pkg::SHADOW: begin
            if (w_wb.taken) begin
               cnt_d = c_shadow_load;
            end else if (cnt_q == 3'd0) begin
               state_d = spu_branch_pkg::IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = spu_branch_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i <= LATENCY; i++) begin
            stg_q[i] <= '0;
         end
         state_q <= spu_branch_pkg::IDLE;
         cnt_q   <= 3'd0;
      end else begin
         for (int i = 1; i <= LATENCY; i++) begin
            stg_q[i] <= stg_d[i];
         end
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign w_wb          = stg_q[LATENCY];
   assign branch_taken  = w_wb.taken;
   assign pc_wb         = w_wb.pc[PC_W-1:0];
   assign rt_addr_wb    = w_wb.rt_addr;
   assign reg_write_wb  = w_wb.reg_write;
   assign shadow_active = (state_q == spu_branch_pkg::SHADOW);
   assign w_unused_pc   = ^w_wb.pc;

   if (REG_W > 32) begin : g_rt_wide
      assign rt_wb = {w_wb.rt, {(REG_W-32){1'b0}}};
   end else begin : g_rt_slot
      assign rt_wb = w_wb.rt;
   end

   a_no_taken_in_shadow: assert property (@(posedge clk) disable iff (!reset)
      !((state_q == spu_branch_pkg::SHADOW) && w_wb.taken));

endmodule

`default_nettype wire

// File: tb/tb_branch_unit_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit_p
// Purpose  : Self-checking bench for branch_unit_p against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit_p;

   localparam int PC_W = 8;
   localparam int REG_W = 128;
   localparam int LAT = 2;
   localparam int SHD = 2;
   localparam longint MOD = longint'(1) << PC_W;

   localparam int K_BI = 0, K_BISL = 1, K_BIZ = 2, K_BINZ = 3, K_BR = 4, K_BRSL = 5;
   localparam int K_BRA = 6, K_BRZ = 7, K_BRNZ = 8, K_BRHZ = 9, K_BRHNZ = 10;
   localparam int K_NOP = 11, K_BADFMT = 12, K_BADRR = 13, K_BADRI = 14;

   logic             clk = 1'b0;
   logic             reset;
   logic [0:10]      op;
   logic [2:0]       format;
   logic [6:0]       rt_addr;
   logic [0:REG_W-1] ra;
   logic [0:REG_W-1] rt_st;
   logic [0:17]      imm;
   logic             reg_write;
   logic [PC_W-1:0]  pc_in;
   logic             first;
   logic [0:REG_W-1] rt_wb;
   logic [6:0]       rt_addr_wb;
   logic             reg_write_wb;
   logic [PC_W-1:0]  pc_wb;
   logic             branch_taken;
   logic             branch_kill;
   logic             shadow_active;

   typedef struct packed {
      logic        taken;
      logic [31:0] pc;
      logic        we;
      logic [6:0]  addr;
      logic [31:0] rt;
   } exp_t;

   exp_t exp_a [0:4095];
   int   n_total = 0;
   int   n_bad = 0;
   int   edge_n = 0;
   int   valid_from = 1;
   int   blocked_until = -1;
   int   last_tk = -100;

   branch_unit_p #(
      .PC_W    (PC_W),
      .REG_W   (REG_W),
      .LATENCY (LAT),
      .SHADOW  (SHD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .op            (op),
      .format        (format),
      .rt_addr       (rt_addr),
      .ra            (ra),
      .rt_st         (rt_st),
      .imm           (imm),
      .reg_write     (reg_write),
      .pc_in         (pc_in),
      .first         (first),
      .rt_wb         (rt_wb),
      .rt_addr_wb    (rt_addr_wb),
      .reg_write_wb  (reg_write_wb),
      .pc_wb         (pc_wb),
      .branch_taken  (branch_taken),
      .branch_kill   (branch_kill),
      .shadow_active (shadow_active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Architectural result of one instruction, ignoring suppression.
   function automatic exp_t ref_decode(input int kind, input longint pc, input longint imm16,
                                       input longint raw, input longint cw, input bit rw,
                                       input int addr);
      exp_t   e;
      longint tgt;
      bit     tk;
      bit     lk;
      e   = '0;
      tk  = 1'b0;
      lk  = 1'b0;
      tgt = (pc + imm16) % MOD;
      case (kind)
         K_BI:    begin tk = 1'b1; tgt = raw % MOD; end
         K_BISL:  begin tk = 1'b1; lk = 1'b1; tgt = raw % MOD; end
         K_BIZ:   begin tk = (cw == 0); tgt = raw % MOD; end
         K_BINZ:  begin tk = (cw != 0); tgt = raw % MOD; end
         K_BR:    tk = 1'b1;
         K_BRSL:  begin tk = 1'b1; lk = 1'b1; end
         K_BRA:   begin tk = 1'b1; tgt = imm16 % MOD; end
         K_BRZ:   tk = (cw == 0);
         K_BRNZ:  tk = (cw != 0);
         K_BRHZ:  tk = ((cw % 65536) == 0);
         K_BRHNZ: tk = ((cw % 65536) != 0);
         default: tk = 1'b0;
      endcase
      e.taken = tk;
      e.pc    = tk ? 32'(tgt) : 32'd0;
      if (lk) begin
         e.rt   = 32'((pc + 1) % MOD);
         e.we   = rw;
         e.addr = 7'(addr);
      end
      return e;
   endfunction

   task automatic check_outputs();
      int   idx;
      exp_t e;
      bit   sh;
      idx = edge_n - LAT + 1;
      e   = (idx >= valid_from) ? exp_a[idx] : exp_t'('0);
      sh  = (edge_n >= last_tk + LAT) && (edge_n <= last_tk + LAT + SHD - 1);
      check_eq("branch_taken", branch_taken, e.taken);
      check_eq("pc_wb", pc_wb, e.pc);
      check_eq("reg_write_wb", reg_write_wb, e.we);
      check_eq("rt_addr_wb", rt_addr_wb, e.addr);
      check_eq("rt_wb", rt_wb, {e.rt, 96'd0});
      check_eq("shadow_active", shadow_active, sh);
   endtask

   // Called at posedge+1; drives one instruction, checks kill, clocks it, checks outputs.
   task automatic issue(input int kind, input longint pc, input longint imm16,
                        input longint raw, input longint cw, input bit fst);
      exp_t        e;
      int          j;
      int          a;
      int          r;
      bit          blk;
      bit          rw;
      logic [10:0] o;
      logic [2:0]  f;
      a  = int'($urandom_range(0, 127));
      rw = (kind == K_BISL || kind == K_BRSL) ? 1'b1 : 1'($urandom_range(0, 1));
      o  = 11'($urandom);
      f  = 3'd5;
      case (kind)
         K_BI:     begin f = 3'd0; o = 11'b00110101000; end
         K_BISL:   begin f = 3'd0; o = 11'b00110101001; end
         K_BIZ:    begin f = 3'd0; o = 11'b00100101000; end
         K_BINZ:   begin f = 3'd0; o = 11'b00100101001; end
         K_BR:     o[8:0] = 9'b001100100;
         K_BRSL:   o[8:0] = 9'b001100110;
         K_BRA:    o[8:0] = 9'b001100000;
         K_BRZ:    o[8:0] = 9'b001000000;
         K_BRNZ:   o[8:0] = 9'b001000010;
         K_BRHZ:   o[8:0] = 9'b001000100;
         K_BRHNZ:  o[8:0] = 9'b001000110;
         K_NOP:    begin f = 3'd0; o = 11'd0; end
         K_BADFMT: begin r = int'($urandom_range(0, 5)); f = 3'((r < 4) ? r + 1 : r + 2); end
         K_BADRR:  begin f = 3'd0; o[10:7] = 4'b1111; end
         default:  o[8:6] = 3'b111;
      endcase
      op        = o;
      format    = f;
      rt_addr   = 7'(a);
      reg_write = rw;
      pc_in     = PC_W'(pc);
      first     = fst;
      imm       = {2'($urandom), 16'(imm16)};
      ra        = {32'(raw), $urandom, $urandom, $urandom};
      rt_st     = {32'(cw), $urandom, $urandom, $urandom};
      e   = ref_decode(kind, pc, imm16, raw, cw, rw, a);
      j   = edge_n + 1;
      blk = (j <= blocked_until);
      #1;
      check_eq("branch_kill", branch_kill, e.taken && fst && !blk);
      if (blk) e = '0;
      exp_a[j] = e;
      if (e.taken) begin
         blocked_until = j + LAT + SHD;
         last_tk       = j;
      end
      @(posedge clk);
      edge_n = j;
      #1;
      check_outputs();
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) issue(K_NOP, 0, 0, 0, 0, 1'b0);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic reset_pulse();
      #2;
      reset = 1'b0;
      #1;
      check_eq("rst_branch_taken", branch_taken, 1'b0);
      check_eq("rst_pc_wb", pc_wb, '0);
      check_eq("rst_rt_wb", rt_wb, '0);
      check_eq("rst_reg_write_wb", reg_write_wb, 1'b0);
      check_eq("rst_rt_addr_wb", rt_addr_wb, '0);
      check_eq("rst_shadow_active", shadow_active, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset         = 1'b1;
      valid_from    = edge_n + 1;
      blocked_until = -1;
      last_tk       = -100;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int     k;
      longint cw;
      reset = 1'b0; op = '0; format = '0; rt_addr = '0; ra = '0; rt_st = '0;
      imm = '0; reg_write = 1'b0; pc_in = '0; first = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_branch_taken", branch_taken, 1'b0);
      check_eq("reset_pc_wb", pc_wb, '0);
      check_eq("reset_rt_wb", rt_wb, '0);
      check_eq("reset_shadow_active", shadow_active, 1'b0);
      check_eq("reset_branch_kill", branch_kill, 1'b0);
      reset = 1'b1;

      issue(K_BR, 'h10, 'h5, 'h77, 'h1, 1'b1);
      nops(1);
      check_eq("plan_br_taken", branch_taken, 1'b1);
      check_eq("plan_br_pc", pc_wb, 'h15);
      check_eq("plan_br_we", reg_write_wb, 1'b0);
      nops(5);

      issue(K_BRSL, 'hFE, 'h4, 'h0, 'h0, 1'b1);
      nops(1);
      check_eq("plan_brsl_pc", pc_wb, 'h02);
      check_eq("plan_brsl_link", rt_wb[0:31], 'hFF);
      check_eq("plan_brsl_we", reg_write_wb, 1'b1);
      nops(5);

      issue(K_BRHZ, 'h20, 'h3, 'h0, 'h00010000, 1'b1);
      nops(5);
      issue(K_BRNZ, 'h20, 'h3, 'h0, 'h00010000, 1'b1);
      nops(5);
      issue(K_BRZ, 'h20, 'h3, 'h0, 'h00010000, 1'b1);
      nops(1);
      check_eq("plan_brz_taken", branch_taken, 1'b0);
      check_eq("plan_brz_pc", pc_wb, 'h0);

      issue(K_BI, 'h40, 'h0, 'h000001A3, 'h0, 1'b0);
      issue(K_BR, 'h41, 'h9, 'h0, 'h0, 1'b1);
      check_eq("plan_bi_pc", pc_wb, 'hA3);
      issue(K_BISL, 'h42, 'h0, 'h55, 'h0, 1'b1);
      nops(5);

      issue(K_BR, 'h30, 'h2, 'h0, 'h0, 1'b1);
      issue(K_BR, 'h31, 'h7, 'h0, 'h0, 1'b1);
      nops(1);
      check_eq("b2b_second_taken", branch_taken, 1'b0);
      nops(5);

      issue(K_BI, 'h50, 'h0, 'h12, 'h0, 1'b1);
      nops(1);
      reset_pulse();
      issue(K_BR, 'h60, 'h1, 'h0, 'h0, 1'b1);
      reset_pulse();
      nops(5);

      for (int it = 0; it < 600; it++) begin
         k = int'($urandom_range(0, K_BADRI));
         case ($urandom_range(0, 3))
            0:       cw = 0;
            1:       cw = 'h10000;
            2:       cw = longint'($urandom_range(0, 65535));
            default: cw = longint'($urandom);
         endcase
         issue(k, longint'($urandom) % MOD, longint'($urandom_range(0, 65535)),
               longint'($urandom), cw, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 63) == 0) reset_pulse();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
